// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 accumulator CPU: opcodes, micro-steps
// and the control word driven by the microcode decoder.
package sap1_pkg;

    localparam int STEPS     = 5;
    localparam int RAM_DEPTH = 16;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_jmp;
        logic mar_in;
        logic ram_in;
        logic ram_out;
        logic instr_in;
        logic instr_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic alu_out;
        logic alu_sub;
        logic out_in;
        logic flags_in;
        logic halt;
    } ctrl_t;

endpackage

// File: rtl/sap1_control.sv
// Combinational microcode decoder: opcode, micro-step and flags to control word.
module sap1_control
    import sap1_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  step_t      step_i,
    input  logic       c_i,
    input  logic       z_i,
    output ctrl_t      ctrl_o
);

    // Fetch on T0/T1, opcode-specific execute on T2..T4
    always_comb begin
        ctrl_o = '0;
        case (step_i)
            T0: begin
                ctrl_o.pc_out = 1'b1;
                ctrl_o.mar_in = 1'b1;
            end
            T1: begin
                ctrl_o.ram_out  = 1'b1;
                ctrl_o.instr_in = 1'b1;
                ctrl_o.pc_inc   = 1'b1;
            end
            default: begin
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        case (step_i)
                            T2: begin
                                ctrl_o.instr_out = 1'b1;
                                ctrl_o.mar_in    = 1'b1;
                            end
                            T3: begin
                                ctrl_o.ram_out = 1'b1;
                                ctrl_o.a_in    = (opcode_i == OP_LDA);
                                ctrl_o.b_in    = (opcode_i != OP_LDA);
                            end
                            T4: begin
                                ctrl_o.alu_out  = (opcode_i != OP_LDA);
                                ctrl_o.a_in     = (opcode_i != OP_LDA);
                                ctrl_o.flags_in = (opcode_i != OP_LDA);
                                ctrl_o.alu_sub  = (opcode_i == OP_SUB);
                            end
                            default: begin end
                        endcase
                    end
                    OP_STA: begin
                        case (step_i)
                            T2: begin
                                ctrl_o.instr_out = 1'b1;
                                ctrl_o.mar_in    = 1'b1;
                            end
                            T3: begin
                                ctrl_o.a_out  = 1'b1;
                                ctrl_o.ram_in = 1'b1;
                            end
                            default: begin end
                        endcase
                    end
                    OP_LDI, OP_JMP, OP_JC, OP_JZ: begin
                        ctrl_o.instr_out = (step_i == T2);
                        ctrl_o.a_in      = (step_i == T2) && (opcode_i == OP_LDI);
                        ctrl_o.pc_jmp    = (step_i == T2) &&
                                           ((opcode_i == OP_JMP) ||
                                            ((opcode_i == OP_JC) && c_i) ||
                                            ((opcode_i == OP_JZ) && z_i));
                    end
                    OP_OUT: begin
                        ctrl_o.a_out  = (step_i == T2);
                        ctrl_o.out_in = (step_i == T2);
                    end
                    OP_HLT: begin
                        ctrl_o.halt = (step_i == T2);
                    end
                    default: begin end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/sap1_cpu.sv
// SAP-1 style 8-bit accumulator CPU: datapath, bus mux, ALU, 16x8 RAM and
// step sequencer around the sap1_control microcode decoder.
module sap1_cpu
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pr_mode,
    input  logic [3:0] pr_address,
    input  logic [7:0] pr_data,
    input  logic       instr_load,
    input  logic       address_send,
    input  logic       debug,
    output logic [7:0] out_data,
    output logic       halted,
    output logic [3:0] dbg_step,
    output logic [7:0] dbg_bus,
    output logic [3:0] dbg_pc
);

    logic [3:0] pc_q, pc_d, mar_q;
    logic [7:0] ir_q, a_q, b_q, out_q;
    logic       c_q, z_q, halted_q;
    step_t      step_q, step_d;
    logic [7:0] ram_q [RAM_DEPTH];

    ctrl_t      ctrl_raw_s, ctrl_s;
    logic [7:0] bus_s, b_op_s;
    logic [8:0] alu_s;

    sap1_control u_control (
        .opcode_i (ir_q[7:4]),
        .step_i   (step_q),
        .c_i      (c_q),
        .z_i      (z_q),
        .ctrl_o   (ctrl_raw_s)
    );

    // Programming mode and halt both silence the microcode
    assign ctrl_s = (pr_mode || halted_q) ? '0 : ctrl_raw_s;

    assign bus_s = ({8{ctrl_s.pc_out}}    & {4'h0, pc_q})      |
                   ({8{ctrl_s.ram_out}}   & ram_q[mar_q])      |
                   ({8{ctrl_s.instr_out}} & {4'h0, ir_q[3:0]}) |
                   ({8{ctrl_s.a_out}}     & a_q)               |
                   ({8{ctrl_s.alu_out}}   & alu_s[7:0]);

    assign b_op_s = ctrl_s.alu_sub ? ~b_q : b_q;
    assign alu_s  = {1'b0, a_q} + {1'b0, b_op_s} + {8'h00, ctrl_s.alu_sub};

    // Next micro-step and next program counter
    always_comb begin
        step_d = step_q;
        if (pr_mode) begin
            step_d = T0;
        end else if (halted_q || ctrl_s.halt) begin
            step_d = step_q;
        end else begin
            case (step_q)
                T0:      step_d = T1;
                T1:      step_d = T2;
                T2:      step_d = T3;
                T3:      step_d = T4;
                default: step_d = T0;
            endcase
        end
        pc_d = pc_q;
        if (ctrl_s.pc_jmp) begin
            pc_d = bus_s[3:0];
        end else if (ctrl_s.pc_inc) begin
            pc_d = pc_q + 4'd1;
        end else begin
            pc_d = pc_q;
        end
    end

    // Architectural registers and sequencer state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q   <= T0;
            pc_q     <= 4'h0;
            mar_q    <= 4'h0;
            ir_q     <= 8'h00;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            out_q    <= 8'h00;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            step_q <= step_d;
            pc_q   <= pc_d;
            if (pr_mode && address_send) mar_q <= pr_address;
            else if (ctrl_s.mar_in)      mar_q <= bus_s[3:0];
            if (ctrl_s.instr_in) ir_q  <= bus_s;
            if (ctrl_s.a_in)     a_q   <= bus_s;
            if (ctrl_s.b_in)     b_q   <= bus_s;
            if (ctrl_s.out_in)   out_q <= bus_s;
            if (ctrl_s.flags_in) begin
                c_q <= alu_s[8];
                z_q <= (alu_s[7:0] == 8'h00);
            end
            if (ctrl_s.halt) halted_q <= 1'b1;
        end
    end

    // RAM has no reset so the program survives rst
    always_ff @(posedge clk) begin
        if (pr_mode && instr_load) ram_q[mar_q] <= pr_data;
        else if (ctrl_s.ram_in)    ram_q[mar_q] <= bus_s;
    end

    assign out_data = out_q;
    assign halted   = halted_q;
    assign dbg_step = debug ? {1'b0, step_q} : 4'h0;
    assign dbg_bus  = debug ? bus_s : 8'h00;
    assign dbg_pc   = debug ? pc_q : 4'h0;

endmodule

// File: tb/tb_sap1_cpu.sv
// Directed bench for sap1_cpu: loads small programs, runs them and scores
// out_data updates against a queue of expected values.
module tb_sap1_cpu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pr_mode = 1'b1;
    logic [3:0] pr_address = 4'h0;
    logic [7:0] pr_data = 8'h00;
    logic       instr_load = 1'b0;
    logic       address_send = 1'b0;
    logic       debug = 1'b1;
    logic [7:0] out_data;
    logic       halted;
    logic [3:0] dbg_step;
    logic [7:0] dbg_bus;
    logic [3:0] dbg_pc;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] prog [16];
    logic [7:0] sb_q [$];

    sap1_cpu dut (
        .clk          (clk),
        .rst          (rst),
        .pr_mode      (pr_mode),
        .pr_address   (pr_address),
        .pr_data      (pr_data),
        .instr_load   (instr_load),
        .address_send (address_send),
        .debug        (debug),
        .out_data     (out_data),
        .halted       (halted),
        .dbg_step     (dbg_step),
        .dbg_bus      (dbg_bus),
        .dbg_pc       (dbg_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        pr_mode = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic prog_write(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        pr_mode = 1'b1;
        address_send = 1'b1;
        pr_address = addr;
        @(negedge clk);
        address_send = 1'b0;
        instr_load = 1'b1;
        pr_data = data;
        @(negedge clk);
        instr_load = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) prog_write(4'(i), prog[i]);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    task automatic run_prog(input int budget);
        logic [7:0] prev;
        logic [2:0] es;
        int c;
        es = 3'd0;
        prev = out_data;
        pr_mode = 1'b0;
        #1;
        c = 0;
        while (!halted && c < budget) begin
            chk("step_seq", {28'h0, dbg_step}, {29'h0, es});
            @(negedge clk);
            es = (es == 3'd4) ? 3'd0 : es + 3'd1;
            if (out_data !== prev) begin
                chk("sb_nonempty", {31'h0, sb_q.size() > 0}, 32'd1);
                if (sb_q.size() > 0) chk("out_data", {24'h0, out_data}, {24'h0, sb_q.pop_front()});
                prev = out_data;
            end
            c++;
        end
        chk("halted", {31'h0, halted}, 32'd1);
        chk("sb_drained", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        // Test 1: LDA 14 / ADD 15 / OUT / HLT, 28 + 14 = 42
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0;
        prog[14] = 8'd28; prog[15] = 8'd14;
        load_prog();
        do_reset();
        #1;
        chk("rst_out", {24'h0, out_data}, 32'd0);
        chk("rst_halted", {31'h0, halted}, 32'd0);
        chk("rst_step", {28'h0, dbg_step}, 32'd0);
        chk("rst_pc", {28'h0, dbg_pc}, 32'd0);
        chk("rst_bus", {24'h0, dbg_bus}, 32'd0);
        sb_q.push_back(8'd42);
        run_prog(200);
        repeat (10) @(negedge clk);
        chk("t1_out_hold", {24'h0, out_data}, 32'd42);
        chk("t1_pc_frozen", {28'h0, dbg_pc}, 32'd4);
        chk("t1_still_halted", {31'h0, halted}, 32'd1);

        // Test 5: async reset during T3 of ADD, then rerun
        do_reset();
        pr_mode = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5_at_t3", {28'h0, dbg_step}, 32'd3);
        chk("t5_a_loaded", {24'h0, dut.a_q}, 32'd28);
        #2 rst = 1'b0;
        #1;
        chk("t5_step0", {28'h0, dbg_step}, 32'd0);
        chk("t5_pc0", {28'h0, dbg_pc}, 32'd0);
        chk("t5_a0", {24'h0, dut.a_q}, 32'd0);
        chk("t5_out0", {24'h0, out_data}, 32'd0);
        chk("t5_ram14", {24'h0, dut.ram_q[14]}, 32'd28);
        chk("t5_ram15", {24'h0, dut.ram_q[15]}, 32'd14);
        @(negedge clk);
        rst = 1'b1;
        sb_q.push_back(8'd42);
        run_prog(200);

        // Test 2: 5 - 7 = 0xFE, borrow so C=0, Z=0
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h3F; prog[2] = 8'hE0; prog[3] = 8'hF0;
        prog[14] = 8'd5; prog[15] = 8'd7;
        load_prog();
        do_reset();
        sb_q.push_back(8'hFE);
        run_prog(200);
        chk("t2_c", {31'h0, dut.c_q}, 32'd0);
        chk("t2_z", {31'h0, dut.z_q}, 32'd0);

        // Test 3: 3 - 3 = 0 so JZ 6 is taken
        clear_prog();
        prog[0] = 8'h53; prog[1] = 8'h3F; prog[2] = 8'h86; prog[3] = 8'hE0; prog[4] = 8'hF0;
        prog[6] = 8'h59; prog[7] = 8'hE0; prog[8] = 8'hF0; prog[15] = 8'd3;
        load_prog();
        do_reset();
        sb_q.push_back(8'd9);
        run_prog(300);
        chk("t3_c", {31'h0, dut.c_q}, 32'd1);
        chk("t3_z", {31'h0, dut.z_q}, 32'd1);

        // Test 4: LDI 1 / STA 13 / LDA 13 / OUT, RAM[13] seeded with 0x77
        clear_prog();
        prog[0] = 8'h51; prog[1] = 8'h4D; prog[2] = 8'h1D; prog[3] = 8'hE0; prog[4] = 8'hF0;
        prog[13] = 8'h77;
        load_prog();
        do_reset();
        sb_q.push_back(8'd1);
        run_prog(300);
        chk("t4_ram13", {24'h0, dut.ram_q[13]}, 32'd1);

        // Test 6: debug gating, then RAM writes while halted
        debug = 1'b0;
        #1;
        chk("t6_dbg_step", {28'h0, dbg_step}, 32'd0);
        chk("t6_dbg_pc", {28'h0, dbg_pc}, 32'd0);
        chk("t6_dbg_bus", {24'h0, dbg_bus}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            logic [3:0] op;
            op = 4'(i);
            prog_write(op, {op, ~op});
            sb_q.push_back({op, ~op});
        end
        for (int i = 0; i < 12; i++) begin
            chk("t6_ram_walk", {24'h0, dut.ram_q[i]}, {24'h0, sb_q.pop_front()});
        end
        @(negedge clk);
        address_send = 1'b1;
        pr_address = 4'd5;
        instr_load = 1'b1;
        pr_data = 8'hAA;
        @(negedge clk);
        address_send = 1'b0;
        pr_data = 8'h55;
        @(negedge clk);
        instr_load = 1'b0;
        chk("t6_old_mar_write", {24'h0, dut.ram_q[11]}, 32'hAA);
        chk("t6_new_mar_write", {24'h0, dut.ram_q[5]}, 32'h55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
